cl_int_divider: RTL and testbench

CL_INT_DIVIDER -- requirements
Module: cl_int_divider

---
 rtl/cl_int_divider.sv | 223 ++++++++++++++++++++++
 tb/tb_cl_int_divider.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cl_int_divider.sv
// -----------------------------------------------------------------------------
// cl_int_divider
//
// Bit-serial divider that works in one of two arithmetic modes, chosen per
// operation:
//   carry_option = 1 : unsigned integer division (borrow subtract)
//   carry_option = 0 : carry-less GF(2)[x] polynomial division (XOR subtract)
//
// Each operation is accepted with a valid/ready handshake and produces one
// quotient bit per clock, MSB of the dividend first. The result is held with
// out_valid until the consumer takes it. Dividing by zero gives an all-ones
// quotient, the dividend as the remainder, and div_by_zero set.
//
// Configuration macro:
//   CL_INT_DIVIDER_ZERO_FAST_EN - when defined, a zero divisor skips the
//                                 iteration phase and goes straight to DONE.
//                                 When undefined, a zero divisor runs the full
//                                 WIDTH iteration cycles like any other input.
//
// Parameters:
//   WIDTH        operand / result width in bits (4..64)
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   carry_option mode select, sampled at acceptance
//   a            dividend, sampled at acceptance
//   b            divisor, sampled at acceptance
//   in_valid     operands valid
//   in_ready     divider idle and able to accept operands
//   quotient     result quotient
//   remainder    result remainder
//   div_by_zero  result came from a zero divisor
//   out_valid    result valid
//   out_ready    consumer accepts the result
//
// State table:
//   state  | meaning
//   IDLE   | waiting for operands, in_ready = 1
//   CALC   | iterating, one quotient bit per cycle
//   DONE   | result presented, out_valid = 1, waiting for out_ready
// -----------------------------------------------------------------------------
module cl_int_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             carry_option,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] dvd_q,   dvd_d;
    logic [WIDTH-1:0] div_q,   div_d;
    logic             mode_q,  mode_d;
    logic [CW-1:0]    deg_q,   deg_d;
    logic [WIDTH-1:0] quo_q,   quo_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic             dbz_q,   dbz_d;

    // Index of the highest set bit; returns 0 for a zero input, which is never
    // used because a zero divisor takes the div_by_zero path.
    function automatic logic [CW-1:0] msb_index(input logic [WIDTH-1:0] v);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                idx = CW'(i);
            end
        end
        return idx;
    endfunction

    // ---------------------------------------------------------------------
    // One iteration step
    // ---------------------------------------------------------------------
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] shifted_lo;
    logic [WIDTH:0]   diff;
    logic             step_bit;
    logic [WIDTH-1:0] step_rem;

    // The full partial remainder is kept in the shift: in integer mode r < b
    // can have its top bit set, so r' needs WIDTH+1 bits.
    assign shifted    = {rem_q, dvd_q[WIDTH-1]};
    assign shifted_lo = shifted[WIDTH-1:0];
    assign diff       = shifted - {1'b0, div_q};

    always_comb begin
        step_bit = 1'b0;
        step_rem = shifted_lo;
        if (dbz_q) begin
            // Zero divisor: every step "subtracts" nothing and sets the
            // quotient bit, so the dividend ends up in the remainder.
            step_bit = 1'b1;
            step_rem = shifted_lo;
        end else if (mode_q) begin
            if (shifted >= {1'b0, div_q}) begin
                step_bit = 1'b1;
                step_rem = diff[WIDTH-1:0];
            end
        end else begin
            // deg(r) < deg(b) holds between steps, so r' never reaches bit
            // WIDTH and only the bit at deg(b) decides the XOR.
            if (shifted_lo[deg_q]) begin
                step_bit = 1'b1;
                step_rem = shifted_lo ^ div_q;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        mode_d  = mode_q;
        deg_d   = deg_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvd_d   = a;
                    div_d   = b;
                    mode_d  = carry_option;
                    deg_d   = msb_index(b);
                    quo_d   = '0;
                    rem_d   = '0;
                    dbz_d   = (b == '0);
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = S_CALC;
`ifdef CL_INT_DIVIDER_ZERO_FAST_EN
                    if (b == '0) begin
                        quo_d   = '1;
                        rem_d   = a;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end
`endif
                end
            end

            S_CALC: begin
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                quo_d = {quo_q[WIDTH-2:0], step_bit};
                rem_d = step_rem;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            mode_q  <= 1'b0;
            deg_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            deg_q   <= deg_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_cl_int_divider.sv
module tb_cl_int_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         carry_option;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         out_valid;
    logic         out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    cl_int_divider #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .carry_option (carry_option),
        .a            (a),
        .b            (b),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Degree of a polynomial (index of highest set bit), -1 for zero.
    function automatic int poly_deg(input logic [63:0] v);
        int d;
        d = -1;
        for (int i = 0; i < 64; i++) if (v[i]) d = i;
        return d;
    endfunction

    // Reference: integer division with the language's / and %, polynomial
    // division by long division on whole aligned multiples of b.
    function automatic void ref_div(input bit mode, input logic [W-1:0] av, input logic [W-1:0] bv,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output bit z);
        logic [63:0] rr;
        int sh;
        z = (bv == 0);
        if (bv == 0) begin
            q = '1;
            r = av;
        end else if (mode) begin
            q = av / bv;
            r = av % bv;
        end else begin
            q  = '0;
            rr = {32'b0, av};
            while (rr != 0 && poly_deg(rr) >= poly_deg({32'b0, bv})) begin
                sh = poly_deg(rr) - poly_deg({32'b0, bv});
                q[sh] = 1'b1;
                rr = rr ^ ({32'b0, bv} << sh);
            end
            r = rr[W-1:0];
        end
    endfunction

    // Division identity on the DUT's outputs, independent of the model.
    function automatic bit identity_ok(input bit mode, input logic [W-1:0] q, input logic [W-1:0] r,
                                       input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [63:0] p;
        if (bv == 0) return (q == '1) && (r == av);
        if (mode) return ({32'b0, q} * {32'b0, bv} + {32'b0, r} == {32'b0, av}) && (r < bv);
        p = '0;
        for (int i = 0; i < W; i++) if (q[i]) p = p ^ ({32'b0, bv} << i);
        return ((p ^ {32'b0, r}) == {32'b0, av}) && (poly_deg({32'b0, r}) < poly_deg({32'b0, bv}));
    endfunction

    task automatic run_op(input bit mode, input logic [W-1:0] av, input logic [W-1:0] bv, input int hold);
        logic [W-1:0] eq, er;
        bit ez;
        int lat, exp_lat;
        ref_div(mode, av, bv, eq, er, ez);
        exp_lat = W;
`ifdef CL_INT_DIVIDER_ZERO_FAST_EN
        if (bv == 0) exp_lat = 0;
`endif
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        carry_option = mode;
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        carry_option = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("quotient", 64'(quotient), 64'(eq));
        check("remainder", 64'(remainder), 64'(er));
        check("div_by_zero", 64'(div_by_zero), 64'(ez));
        check("identity", 64'(identity_ok(mode, quotient, remainder, av, bv)), 64'd1);
        check("no_ready_with_valid", 64'(in_ready & out_valid), 64'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_quotient", 64'(quotient), 64'(eq));
            check("hold_remainder", 64'(remainder), 64'(er));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit rm;

        rst_n        = 1'b0;
        carry_option = 1'b0;
        a            = '0;
        b            = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_div_by_zero", 64'(div_by_zero), 64'd0);

        run_op(1'b1, 32'd100, 32'd7, 0);
        check("int_100_7_q", 64'(quotient), 64'd14);
        run_op(1'b0, 32'h0000000D, 32'h00000003, 0);
        check("clmul_d_3_q", 64'(quotient), 64'd4);
        run_op(1'b1, 32'h12345678, 32'h0, 0);
        run_op(1'b0, 32'h12345678, 32'h0, 0);
        run_op(1'b1, 32'h9ABCDEF0, 32'h00001234, 10);
        run_op(1'b0, 32'hFFFFFFFF, 32'h80000001, 0);
        run_op(1'b1, 32'h00000005, 32'hFFFFFFFF, 0);
        run_op(1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 0);
        run_op(1'b0, 32'h80000000, 32'h00000001, 0);

        // Reset in the middle of an operation.
        @(negedge clk);
        carry_option = 1'b1;
        a = 32'hDEADBEEF;
        b = 32'h00000011;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_quotient", 64'(quotient), 64'd0);
        check("midrst_remainder", 64'(remainder), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid_rel", 64'(out_valid), 64'd0);
        run_op(1'b1, 32'hFFFFFFFF, 32'h00000001, 0);

        for (int i = 0; i < 1000; i++) begin
            rm = 1'($urandom);
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) rb = '0;
            run_op(rm, ra, rb, (i % 97 == 0) ? 3 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
